// File: rtl/one_hot_to_binary_reg.sv
// one_hot_to_binary_reg: registered one-hot to binary encoder with valid/ready handshake and saturating error count
// Ports: clk, reset (sync, active-high); one_hot_i/in_valid_i/in_ready_o upstream;
// bin_o/err_o/out_valid_o/out_ready_i downstream; clr_cnt_i/err_cnt_o malformed-word counter.
// ONE_HOT_PRIO_EN: multi-hot words encode to their highest set bit instead of flagging an error.
module one_hot_to_binary_reg #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 clr_cnt_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  logic [BIN_W-1:0] top_bin;
  logic [BIN_W-1:0] enc_bin;
  logic             enc_err;
  logic             accept;
  always_comb begin
    top_bin = '0;
    for (int i = 0; i < ONE_HOT_W; i++) top_bin = one_hot_i[i] ? BIN_W'(i) : top_bin;
  end
`ifdef ONE_HOT_PRIO_EN
  assign enc_err = ~|one_hot_i;
  assign enc_bin = top_bin;
`else
  // w & (w-1) clears the lowest set bit; anything left means more than one bit was set
  assign enc_err = ~|one_hot_i | (|(one_hot_i & (one_hot_i - ONE_HOT_W'(1))));
  assign enc_bin = enc_err ? '0 : top_bin;
`endif
  assign in_ready_o = !reset && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      bin_o       <= '0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      if (accept) begin
        out_valid_o <= 1'b1;
        bin_o       <= enc_bin;
        err_o       <= enc_err;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (clr_cnt_i) err_cnt_o <= '0;
      else if (accept && enc_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_one_hot_to_binary_reg.sv
// tb_one_hot_to_binary_reg: directed and random checks of one_hot_to_binary_reg against a behavioural model
module tb_one_hot_to_binary_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] one_hot = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        in_ready, err, out_valid;
  logic        in_ready_s, err_s, out_valid_s;
  logic [3:0]  bin, bin_s;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt_s;
  int          checks = 0;
  int          errors = 0;
  logic        m_valid, m_err;
  logic [3:0]  m_bin;
  int          m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  one_hot_to_binary_reg dut (
    .clk(clk), .reset(reset), .one_hot_i(one_hot), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .bin_o(bin), .err_o(err), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .clr_cnt_i(clr_cnt), .err_cnt_o(err_cnt)
  );

  one_hot_to_binary_reg #(.ERR_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .one_hot_i(one_hot), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .bin_o(bin_s), .err_o(err_s), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .clr_cnt_i(clr_cnt), .err_cnt_o(err_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void encode(input logic [15:0] w, output logic [3:0] b, output logic e);
`ifdef ONE_HOT_PRIO_EN
    e = (w == 16'h0);
    b = e ? 4'd0 : 4'($clog2(int'(w) + 1) - 1);
`else
    e = ($countones(w) != 1);
    b = e ? 4'd0 : 4'($clog2(int'(w)));
`endif
  endfunction

  task automatic cycle();
    logic       acc, e_err, e_rdy;
    logic [3:0] e_bin;
    #1;
    e_rdy = !reset && (!m_valid || out_ready);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("in_ready_s", 32'(in_ready_s), 32'(e_rdy));
    acc = in_valid && e_rdy;
    encode(one_hot, e_bin, e_err);
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 0; m_bin = 0; m_err = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (acc) begin
        m_valid = 1; m_bin = e_bin; m_err = e_err;
      end else if (out_ready) m_valid = 0;
      if (clr_cnt) begin
        m_cnt = 0; m_cnt_s = 0;
      end else if (acc && e_err) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : 3;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("bin", 32'(bin), 32'(m_bin));
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("err_cnt_sat2", 32'(err_cnt_s), 32'(m_cnt_s));
  endtask

  task automatic put(input logic [15:0] w, input logic v, input logic r, input logic c);
    one_hot = w; in_valid = v; out_ready = r; clr_cnt = c;
    cycle();
  endtask

  initial begin
    m_valid = 0; m_bin = 0; m_err = 0; m_cnt = 0; m_cnt_s = 0;
    reset = 1;
    put(16'h0, 0, 0, 0);
    put(16'h1, 1, 1, 0);
    reset = 0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    chk("valid_after_reset", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      put(16'(1 << i), 1, 1, 0);
      chk("walk_bin", 32'(bin), 32'(i));
    end
    put(16'h0000, 1, 1, 0);
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_cnt", 32'(err_cnt), 32'd1);
    put(16'h0104, 1, 1, 0);
`ifdef ONE_HOT_PRIO_EN
    chk("multi_bin", 32'(bin), 32'd8);
    chk("multi_cnt", 32'(err_cnt), 32'd1);
`else
    chk("multi_err", 32'(err), 32'd1);
    chk("multi_cnt", 32'(err_cnt), 32'd2);
`endif
    put(16'h0020, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      put(16'h0400, 1, 0, 0);
      chk("hold_bin", 32'(bin), 32'd5);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    put(16'h0400, 1, 1, 0);
    chk("release_bin", 32'(bin), 32'd10);
    put(16'h0, 0, 1, 0);
    for (int i = 0; i < 5; i++) put(16'h0, 1, 1, 0);
    chk("sat2", 32'(err_cnt_s), 32'd3);
    put(16'h0, 1, 1, 1);
    chk("clr_over_inc", 32'(err_cnt_s), 32'd0);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] w;
      case ($urandom_range(0, 3))
        0: w = 16'h0;
        1, 2: w = 16'(1 << $urandom_range(0, 15));
        default: w = 16'($urandom);
      endcase
      put(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 270; i++) put(16'h0, 1, 1, 0);
    chk("sat8", 32'(err_cnt), 32'd255);
    put(16'h0080, 1, 1, 0);
    put(16'h0, 0, 0, 0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1;
    put(16'h0, 0, 0, 0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_bin", 32'(bin), 32'd0);
    chk("reset_cnt", 32'(err_cnt), 32'd0);
    reset = 0;
    put(16'h0002, 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
